edge_gen: RTL and testbench
===========================

EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 SHALL have parameter CW, default 8, width of the high_cycles and low_cycles fields.
REQ-002 SHALL have parameter NW, default 4, width of the num_pulses field.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, request to begin a pulse train; sampled only when busy=0.
REQ-006 SHALL have port abort, input, 1, terminates an active train.
REQ-007 SHALL have port high_cycles, input, CW, high-phase length in clocks; sampled with start.
REQ-008 SHALL have port low_cycles, input, CW, low-phase length in clocks; sampled with start.
REQ-009 SHALL have port num_pulses, input, NW, number of pulses (falling edges) in the train; sampled with start.
REQ-010 SHALL have port signal, output, 1, registered waveform; its falling edges are the generated events.
REQ-011 SHALL have port busy, output, 1, registered; high while a train is active.
REQ-012 SHALL have port done, output, 1, registered one-cycle pulse at train completion.

Function
REQ-013 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-014 SHALL accept start only in IDLE: start=1 and busy=0 at an edge.
REQ-015 On an accepted start with high_cycles!=0 and num_pulses!=0, SHALL latch all three config fields, enter HIGH, and set signal=1 and busy=1 at that same edge (zero-cycle latency from the sampling edge).
REQ-016 On an accepted start with high_cycles=0 or num_pulses=0, SHALL stay in IDLE with signal=0, busy=0, and done=1 for exactly one cycle.
REQ-017 SHALL hold signal=1 for exactly latched high_cycles clocks in HIGH; on the last of those clocks it SHALL drive signal=0 at the next edge, producing one falling edge.
REQ-018 SHALL, after a HIGH phase that is not the last pulse, enter LOW with signal=0 for exactly max(low_cycles,1) clocks, then re-enter HIGH with signal=1.
REQ-019 SHALL treat low_cycles=0 as 1, so every falling edge is separated by at least one low cycle.
REQ-020 SHALL, at the edge ending the final HIGH phase, go to IDLE and set signal=0, busy=0 and done=1 together; it SHALL emit no trailing LOW phase.
REQ-021 SHALL hold done for one cycle only; it SHALL be 0 in all other cycles.
REQ-022 SHALL ignore start while busy=1; this includes the done cycle, where busy is already 0 at the output but was 1 when start was sampled.
REQ-023 SHALL, on abort=1 at any edge in HIGH or LOW, go to IDLE with signal=0 and busy=0, without asserting done.
REQ-024 SHALL ignore abort in IDLE.
REQ-025 SHALL give abort priority over phase progression; reset SHALL take priority over abort and start.
REQ-026 SHALL ignore changes on config inputs while busy=1.
REQ-027 SHALL use a CW-bit phase counter and an NW-bit pulse counter, each with no wrap-around: maximum values 2^CW-1 and 2^NW-1 SHALL be honoured exactly.
REQ-028 SHALL make total train length equal to N*H + (N-1)*max(L,1) clocks from the accepting edge to the done edge.

Reset
REQ-029 With rst_n=0 at an edge, SHALL set state=IDLE, signal=0, busy=0, done=0, and clear both counters.
REQ-030 SHALL abandon a train on reset mid-operation with no done pulse; the first start accepted after release SHALL behave per REQ-015.

Verification
REQ-031 Single pulse: H=3, L=2, N=1, start at edge t0 -> signal=1 after edges t0..t0+2, falls at t0+3; done=1 and busy=0 at t0+3.
REQ-032 Train: H=2, L=2, N=3 -> signal pattern 1,1,0,0,1,1,0,0,1,1 then 0; exactly 3 falling edges; done at edge t0+10.
REQ-033 Low clamp: H=1, L=0, N=4 -> signal alternates 1,0,1,0,1,0,1 then 0; done coincides with 4th fall.
REQ-034 Zero config: start with N=0 (then with H=0) -> signal stays 0, busy stays 0, done=1 for one cycle.
REQ-035 Start while busy: H=5, N=2, second start during HIGH and another in the done cycle -> both ignored; waveform unchanged.
REQ-036 Abort and reset: abort in the second LOW phase of N=3 -> signal=0 and busy=0 next edge, no done; repeat with rst_n=0 mid-HIGH -> all outputs 0, and a new start afterwards runs normally.

Source files
------------

// File: rtl/edge_gen.sv
// Programmable pulse-train generator: emits num_pulses high/low cycles on
// `signal`, with busy while active and a one-cycle done at train completion.
module edge_gen #(
  parameter int CW = 8,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] high_cycles,
  input  logic [CW-1:0] low_cycles,
  input  logic [NW-1:0] num_pulses,
  output logic          signal,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] phase_cnt, phase_nxt;
  logic [NW-1:0] pulse_cnt, pulse_nxt;
  logic [CW-1:0] high_len, high_nxt;
  logic [CW-1:0] low_len, low_nxt;
  logic          signal_nxt, busy_nxt, done_nxt;

  logic cfg_ok;
  logic phase_last;
  logic pulse_last;

  assign cfg_ok     = (high_cycles != '0) && (num_pulses != '0);
  assign phase_last = (phase_cnt == CW'(1));
  assign pulse_last = (pulse_cnt == NW'(1));

  // State register and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      high_len  <= '0;
      low_len   <= '0;
      signal    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      pulse_cnt <= pulse_nxt;
      high_len  <= high_nxt;
      low_len   <= low_nxt;
      signal    <= signal_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic. phase_cnt holds the clocks still to spend in the
  // current phase, so the phase ends on the edge where it reads 1.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    pulse_nxt = pulse_cnt;
    high_nxt  = high_len;
    low_nxt   = low_len;
    unique case (state)
      IDLE: begin
        if (start && cfg_ok) begin
          state_nxt = HIGH;
          high_nxt  = high_cycles;
          low_nxt   = (low_cycles == '0) ? CW'(1) : low_cycles;
          phase_nxt = high_cycles;
          pulse_nxt = num_pulses;
        end
      end
      HIGH: begin
        if (abort) begin
          state_nxt = IDLE;
          phase_nxt = '0;
          pulse_nxt = '0;
        end else if (phase_last) begin
          if (pulse_last) begin
            state_nxt = IDLE;
            phase_nxt = '0;
            pulse_nxt = '0;
          end else begin
            state_nxt = LOW;
            phase_nxt = low_len;
            pulse_nxt = pulse_cnt - NW'(1);
          end
        end else begin
          phase_nxt = phase_cnt - CW'(1);
        end
      end
      LOW: begin
        if (abort) begin
          state_nxt = IDLE;
          phase_nxt = '0;
          pulse_nxt = '0;
        end else if (phase_last) begin
          state_nxt = HIGH;
          phase_nxt = high_len;
        end else begin
          phase_nxt = phase_cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
        pulse_nxt = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs. done fires on a
  // degenerate start or on the natural end of the last HIGH phase, never on abort.
  always_comb begin
    signal_nxt = (state_nxt == HIGH);
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = ((state == IDLE) && start && !cfg_ok) ||
                 ((state == HIGH) && !abort && phase_last && pulse_last);
  end

endmodule

// File: tb/tb_edge_gen.sv
// Self-checking bench for edge_gen: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based waveform model.
module tb_edge_gen;

  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] high_cycles;
  logic [CW-1:0] low_cycles;
  logic [NW-1:0] num_pulses;
  logic          signal;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Each entry is the expected {signal, busy, done} after one future edge.
  logic [2:0] exp_q[$];

  edge_gen #(.CW(CW), .NW(NW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .num_pulses  (num_pulses),
    .signal      (signal),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand one accepted start into the full expected waveform.
  task automatic build_train(input int h, input int l, input int n);
    int lc;
    lc = (l == 0) ? 1 : l;
    if (h == 0 || n == 0) begin
      exp_q.push_back(3'b001);
    end else begin
      for (int p = 1; p <= n; p++) begin
        for (int i = 0; i < h; i++) exp_q.push_back(3'b110);
        if (p < n)
          for (int i = 0; i < lc; i++) exp_q.push_back(3'b010);
      end
      exp_q.push_back(3'b001);
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, compare outputs shortly after it.
  task automatic step(input string tag, input logic s, input logic a,
                      input int h, input int l, input int n, input logic r);
    logic [2:0] expv;
    @(negedge clk);
    start       = s;
    abort       = a;
    high_cycles = CW'(h);
    low_cycles  = CW'(l);
    num_pulses  = NW'(n);
    rst_n       = r;
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      expv = 3'b000;
    end else if (exp_q.size() != 0) begin
      if (a) begin
        exp_q.delete();
        expv = 3'b000;
      end else begin
        expv = exp_q.pop_front();
      end
    end else if (s) begin
      build_train(h, l, n);
      expv = exp_q.pop_front();
    end else begin
      expv = 3'b000;
    end
    #1;
    check(tag, {29'd0, signal, busy, done}, {29'd0, expv});
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic run_train(input string tag, input int h, input int l, input int n, input int tail);
    step(tag, 1'b1, 1'b0, h, l, n, 1'b1);
    idle(tag, tail);
  endtask

  int falls;
  logic prev_sig;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    high_cycles = '0; low_cycles = '0; num_pulses = '0;

    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b1, 3, 3, 3, 1'b0);
    idle("post_reset", 2);

    run_train("single", 3, 2, 1, 6);

    // Train with falling-edge count and done position.
    falls = 0;
    prev_sig = 1'b0;
    step("train", 1'b1, 1'b0, 2, 2, 3, 1'b1);
    prev_sig = signal;
    for (int k = 1; k <= 12; k++) begin
      step("train", 1'b0, 1'b0, 0, 0, 0, 1'b1);
      if (prev_sig && !signal) falls++;
      prev_sig = signal;
      if (k == 10) check("train_done_at_10", {31'd0, done}, 32'd1);
    end
    check("train_falls", falls, 3);

    run_train("low_clamp", 1, 0, 4, 10);
    run_train("zero_n", 4, 2, 0, 3);
    run_train("zero_h", 0, 2, 5, 3);
    // Back-to-back degenerate starts: each accepted since busy stays 0.
    step("zero_b2b", 1'b1, 1'b0, 0, 1, 1, 1'b1);
    step("zero_b2b", 1'b1, 1'b0, 3, 1, 0, 1'b1);
    idle("zero_b2b", 2);

    // Starts during HIGH and on the done edge are ignored; one after is taken.
    for (int k = 0; k <= 13; k++) begin
      if (k == 0)                    step("busy_start", 1'b1, 1'b0, 5, 1, 2, 1'b1);
      else if (k == 2 || k == 11)    step("busy_start", 1'b1, 1'b0, 1, 1, 1, 1'b1);
      else                           step("busy_start", 1'b0, 1'b0, 0, 0, 0, 1'b1);
    end
    idle("busy_start", 2);
    step("start_after_done", 1'b1, 1'b0, 1, 0, 1, 1'b1);
    step("start_after_done", 1'b1, 1'b0, 2, 0, 1, 1'b1);
    idle("start_after_done", 4);

    // Abort in the second LOW phase (H=2, L=3: second LOW spans edges 7..9).
    step("abort", 1'b1, 1'b0, 2, 3, 3, 1'b1);
    for (int k = 1; k <= 12; k++) step("abort", 1'b0, (k == 8), 0, 0, 0, 1'b1);
    step("abort_idle", 1'b0, 1'b1, 0, 0, 0, 1'b1);
    // Abort on the final edge suppresses done.
    step("abort_last", 1'b1, 1'b0, 2, 1, 1, 1'b1);
    step("abort_last", 1'b0, 1'b0, 0, 0, 0, 1'b1);
    step("abort_last", 1'b0, 1'b1, 0, 0, 0, 1'b1);
    idle("abort_last", 2);

    // Reset mid-HIGH, then a fresh start runs normally.
    step("reset_mid", 1'b1, 1'b0, 6, 2, 2, 1'b1);
    step("reset_mid", 1'b0, 1'b0, 0, 0, 0, 1'b1);
    step("reset_mid", 1'b0, 1'b0, 0, 0, 0, 1'b1);
    step("reset_mid", 1'b1, 1'b0, 6, 2, 2, 1'b0);
    idle("reset_mid", 2);
    run_train("after_reset", 3, 1, 2, 10);

    // Counter extremes.
    run_train("max_high", 255, 0, 2, 515);
    run_train("max_low_n", 2, 255, 15, 3603);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step("random",
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0),
           $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 5),
           ($urandom_range(0, 199) != 0));
    end
    idle("drain", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
